// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - HH:MM:SS BCD time-of-day counter with 1 Hz prescaler, set pulses and alarm
//
// Purpose: divides clk_i down to a 1 Hz tick and keeps time as six BCD digits,
// each feeding a 7-segment decoder. Single-cycle set pulses step minutes or
// hours. A registered one-cycle alarm_hit_o fires when a tick lands on the
// programmed HH:MM:00.
//
// Optional feature macro: TWELVE_HOUR_EN (12-hour display with pm flag).
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        synchronous active-high reset
//   run_i          1 = prescaler advances, 0 = frozen
//   inc_min_i      one-cycle pulse, minutes +1 (no carry), clears seconds
//   inc_hr_i       one-cycle pulse, hours +1, clears seconds
//   alarm_en_i     enables the alarm compare
//   alarm_hh_i     alarm hours, BCD {tens,units}
//   alarm_mm_i     alarm minutes, BCD {tens,units}
//   alarm_pm_i     alarm pm flag (TWELVE_HOUR_EN only)
//   sec_lo_o..hr_hi_o  time digits, BCD
//   pm_o           pm flag (TWELVE_HOUR_EN only)
//   sec_pulse_o    one-cycle pulse after every 1 Hz advance
//   alarm_hit_o    one-cycle pulse after a tick that reaches the alarm time

module bcd_time_counter #(
    parameter int CLK_HZ = 50000000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       run_i,
    input  logic       inc_min_i,
    input  logic       inc_hr_i,
    input  logic       alarm_en_i,
    input  logic [7:0] alarm_hh_i,
    input  logic [7:0] alarm_mm_i,
`ifdef TWELVE_HOUR_EN
    input  logic       alarm_pm_i,
    output logic       pm_o,
`endif
    output logic [3:0] sec_lo_o,
    output logic [3:0] sec_hi_o,
    output logic [3:0] min_lo_o,
    output logic [3:0] min_hi_o,
    output logic [3:0] hr_lo_o,
    output logic [3:0] hr_hi_o,
    output logic       sec_pulse_o,
    output logic       alarm_hit_o
);

    localparam int                CNT_W   = $clog2(CLK_HZ);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_HZ - 1);
`ifdef TWELVE_HOUR_EN
    localparam logic [7:0]        HR_RESET = 8'h12;
`else
    localparam logic [7:0]        HR_RESET = 8'h00;
`endif

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       sec_q, sec_d;
    logic [7:0]       min_q, min_d;
    logic [7:0]       hr_q, hr_d;
    logic             sec_pulse_q, sec_pulse_d;
    logic             alarm_hit_q, alarm_hit_d;
`ifdef TWELVE_HOUR_EN
    logic             pm_q, pm_d;
    logic             pm_flip;
`endif

    logic       set_pulse;
    logic       tick;
    logic [8:0] sec_inc;   // {carry, next value}
    logic [8:0] min_inc;
    logic [7:0] hr_next;
    logic       alarm_match;

    // Digit-wise BCD increment modulo 60; bit 8 is the carry out of 59.
    function automatic logic [8:0] bcd_inc60(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) begin
                return 9'h100;
            end
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        end
        return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    // Hour step: 12-hour sequence is 12,01..11; 24-hour sequence is 00..23.
    function automatic logic [7:0] hr_step(input logic [7:0] v);
`ifdef TWELVE_HOUR_EN
        if (v == 8'h12) begin
            return 8'h01;
        end
`else
        if (v == 8'h23) begin
            return 8'h00;
        end
`endif
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign set_pulse = inc_min_i | inc_hr_i;
    assign tick      = run_i & (cnt_q == CNT_MAX);
    assign sec_inc   = bcd_inc60(sec_q);
    assign min_inc   = bcd_inc60(min_q);
    assign hr_next   = hr_step(hr_q);
`ifdef TWELVE_HOUR_EN
    // Crossing 11 -> 12 is the am/pm boundary in both directions.
    assign pm_flip   = (hr_q == 8'h11);
`endif

    always_comb begin
        cnt_d       = cnt_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hr_d        = hr_q;
        sec_pulse_d = 1'b0;
        alarm_hit_d = 1'b0;
        alarm_match = 1'b0;
`ifdef TWELVE_HOUR_EN
        pm_d        = pm_q;
`endif
        if (set_pulse) begin
            // Set pulses take priority; a coincident tick is dropped.
            cnt_d = '0;
            sec_d = 8'h00;
            if (inc_min_i) begin
                min_d = min_inc[7:0];
            end
            if (inc_hr_i) begin
                hr_d = hr_next;
`ifdef TWELVE_HOUR_EN
                pm_d = pm_q ^ pm_flip;
`endif
            end
        end else if (run_i) begin
            if (tick) begin
                cnt_d = '0;
                sec_d = sec_inc[7:0];
                if (sec_inc[8]) begin
                    min_d = min_inc[7:0];
                    if (min_inc[8]) begin
                        hr_d = hr_next;
`ifdef TWELVE_HOUR_EN
                        pm_d = pm_q ^ pm_flip;
`endif
                    end
                end
                sec_pulse_d = 1'b1;
                // Digits are always BCD, so non-BCD alarm values never match.
                alarm_match = (hr_d == alarm_hh_i) && (min_d == alarm_mm_i) && (sec_d == 8'h00);
`ifdef TWELVE_HOUR_EN
                alarm_match = alarm_match && (pm_d == alarm_pm_i);
`endif
                alarm_hit_d = alarm_en_i & alarm_match;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q       <= '0;
            sec_q       <= 8'h00;
            min_q       <= 8'h00;
            hr_q        <= HR_RESET;
            sec_pulse_q <= 1'b0;
            alarm_hit_q <= 1'b0;
`ifdef TWELVE_HOUR_EN
            pm_q        <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hr_q        <= hr_d;
            sec_pulse_q <= sec_pulse_d;
            alarm_hit_q <= alarm_hit_d;
`ifdef TWELVE_HOUR_EN
            pm_q        <= pm_d;
`endif
        end
    end

    assign sec_lo_o    = sec_q[3:0];
    assign sec_hi_o    = sec_q[7:4];
    assign min_lo_o    = min_q[3:0];
    assign min_hi_o    = min_q[7:4];
    assign hr_lo_o     = hr_q[3:0];
    assign hr_hi_o     = hr_q[7:4];
    assign sec_pulse_o = sec_pulse_q;
    assign alarm_hit_o = alarm_hit_q;
`ifdef TWELVE_HOUR_EN
    assign pm_o        = pm_q;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - self-checking bench for bcd_time_counter against a seconds-of-day model

module tb_bcd_time_counter;

    localparam int CLK_HZ = 4;
    localparam int DAY    = 86400;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       inc_min = 1'b0;
    logic       inc_hr = 1'b0;
    logic       alarm_en = 1'b0;
    logic [7:0] alarm_hh = 8'h00;
    logic [7:0] alarm_mm = 8'h00;
    logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
    logic       sec_pulse, alarm_hit;
    logic       pm;
`ifdef TWELVE_HOUR_EN
    logic       alarm_pm = 1'b0;
`else
    assign pm = 1'b0;
`endif

    bcd_time_counter #(.CLK_HZ(CLK_HZ)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .run_i       (run),
        .inc_min_i   (inc_min),
        .inc_hr_i    (inc_hr),
        .alarm_en_i  (alarm_en),
        .alarm_hh_i  (alarm_hh),
        .alarm_mm_i  (alarm_mm),
`ifdef TWELVE_HOUR_EN
        .alarm_pm_i  (alarm_pm),
        .pm_o        (pm),
`endif
        .sec_lo_o    (sec_lo),
        .sec_hi_o    (sec_hi),
        .min_lo_o    (min_lo),
        .min_hi_o    (min_hi),
        .hr_lo_o     (hr_lo),
        .hr_hi_o     (hr_hi),
        .sec_pulse_o (sec_pulse),
        .alarm_hit_o (alarm_hit)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;

    // Reference model: time as plain seconds since midnight, prescaler as an int.
    int   m_tod = 0;
    int   m_presc = 0;
    logic m_sp = 1'b0;
    logic m_ah = 1'b0;

    function automatic logic [7:0] bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    function automatic int alarm_target();
        int h, m;
        if (alarm_hh[7:4] > 4'd9 || alarm_hh[3:0] > 4'd9 ||
            alarm_mm[7:4] > 4'd9 || alarm_mm[3:0] > 4'd9) return -1;
        h = 10 * int'(alarm_hh[7:4]) + int'(alarm_hh[3:0]);
        m = 10 * int'(alarm_mm[7:4]) + int'(alarm_mm[3:0]);
        if (m > 59) return -1;
`ifdef TWELVE_HOUR_EN
        if (h < 1 || h > 12) return -1;
        h = (h % 12) + (alarm_pm ? 12 : 0);
`else
        if (h > 23) return -1;
`endif
        return h * 3600 + m * 60;
    endfunction

    function automatic logic [26:0] exp_vec();
        int h24, hd;
        logic pmv;
        h24 = m_tod / 3600;
`ifdef TWELVE_HOUR_EN
        hd  = (h24 % 12 == 0) ? 12 : h24 % 12;
        pmv = (h24 >= 12);
`else
        hd  = h24;
        pmv = 1'b0;
`endif
        return {bcd(hd), bcd((m_tod / 60) % 60), bcd(m_tod % 60), m_sp, m_ah, pmv};
    endfunction

    function automatic logic [26:0] obs_vec();
        return {hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo, sec_pulse, alarm_hit, pm};
    endfunction

    function automatic logic [23:0] obs_digits();
        return {hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo};
    endfunction

    // One clock edge: advance the model with the inputs held across the edge, sample 1 ns later.
    task automatic cycle();
        bit tick;
        int h, m;
        @(posedge clk);
        if (reset) begin
            m_tod = 0; m_presc = 0; m_sp = 1'b0; m_ah = 1'b0;
        end else if (inc_min || inc_hr) begin
            h = m_tod / 3600;
            m = (m_tod / 60) % 60;
            if (inc_min) m = (m + 1) % 60;
            if (inc_hr)  h = (h + 1) % 24;
            m_tod = h * 3600 + m * 60;
            m_presc = 0; m_sp = 1'b0; m_ah = 1'b0;
        end else begin
            tick = run && (m_presc == CLK_HZ - 1);
            if (run) m_presc = tick ? 0 : m_presc + 1;
            if (tick) m_tod = (m_tod + 1) % DAY;
            m_sp = tick;
            m_ah = tick && alarm_en && (m_tod == alarm_target());
        end
        #1;
    endtask

    task automatic set_time(input int h, input int m);
        run = 1'b0;
        inc_min = 1'b1; cycle(); inc_min = 1'b0;
        for (int i = 0; i < 24 && (m_tod / 3600) != h; i++) begin
            inc_hr = 1'b1; cycle(); inc_hr = 1'b0;
        end
        for (int i = 0; i < 60 && ((m_tod / 60) % 60) != m; i++) begin
            inc_min = 1'b1; cycle(); inc_min = 1'b0;
        end
    endtask

    task automatic run_to(input int target);
        int n;
        run = 1'b1;
        n = 0;
        while (m_tod != target && n < 300 * CLK_HZ) begin
            cycle();
            n++;
        end
        checks++;
        if (m_tod != target) begin
            errors++;
            $display("FAIL run_to_timeout got %0d want %0d", m_tod, target);
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; run = 1'b1; inc_min = 1'b1;
        cycle(); cycle();
        inc_min = 1'b0;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_state got %h want %h", obs_vec(), exp_vec());
        end
        reset = 1'b0;
        n = 0;
        do begin
            cycle();
            n++;
        end while (sec_pulse !== 1'b1 && n < 10);
        checks++;
        if (n !== CLK_HZ || sec_lo !== 4'd1) begin
            errors++;
            $display("FAIL first_tick got cycles=%0d sec_lo=%0d want cycles=%0d sec_lo=1", n, sec_lo, CLK_HZ);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL first_tick_state got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_day_wrap();
        int pulses, n, last;
        set_time(23, 59);
        run_to(DAY - 2);
        pulses = 0; n = 0;
        while (pulses < 2 && n < 20) begin
            cycle(); n++;
            if (sec_pulse === 1'b1) pulses++;
        end
        checks++;
        if (obs_digits() !== 24'h0 || m_tod != 0 || obs_vec() !== exp_vec()) begin
            errors++;
`ifndef TWELVE_HOUR_EN
            $display("FAIL day_wrap got %h want 000000", obs_digits());
`else
            $display("FAIL day_wrap got %h want %h", obs_vec(), exp_vec());
`endif
        end
        last = 0; n = 0;
        for (int p = 0; p < 3; p++) begin
            n = 0;
            do begin cycle(); n++; end while (sec_pulse !== 1'b1 && n < 10);
            checks++;
            if (n !== CLK_HZ) begin
                errors++;
                $display("FAIL tick_spacing got %0d want %0d", n, CLK_HZ);
            end
        end
    endtask

    task automatic test_set_pulses();
        set_time(12, 59);
        run_to(12 * 3600 + 59 * 60 + 30);
        inc_min = 1'b1; cycle(); inc_min = 1'b0;
        checks++;
        if (obs_digits() !== 24'h120000 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL inc_min_no_carry got %h want 120000", obs_digits());
        end
        set_time(23, 17);
        run_to(23 * 3600 + 17 * 60 + 10);
        inc_hr = 1'b1; cycle(); inc_hr = 1'b0;
        checks++;
`ifdef TWELVE_HOUR_EN
        if (obs_digits() !== 24'h121700 || pm !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL inc_hr_wrap got %h pm=%b want 121700 pm=0", obs_digits(), pm);
        end
`else
        if (obs_digits() !== 24'h001700 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL inc_hr_wrap got %h want 001700", obs_digits());
        end
`endif
    endtask

    task automatic test_alarm();
        int n;
        alarm_hh = 8'h07; alarm_mm = 8'h30;
        for (int pass = 0; pass < 2; pass++) begin
            alarm_en = (pass == 0);
            set_time(7, 29);
            run_to(7 * 3600 + 29 * 60 + 59);
            n = 0;
            do begin cycle(); n++; end while (sec_pulse !== 1'b1 && n < 10);
            checks++;
            if (alarm_hit !== (pass == 0) || obs_digits() !== 24'h073000 || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL alarm_tick en=%0d got hit=%b time=%h want hit=%0d time=073000",
                         alarm_en, alarm_hit, obs_digits(), pass == 0);
            end
            cycle();
            checks++;
            if (alarm_hit !== 1'b0) begin
                errors++;
                $display("FAIL alarm_one_cycle got %b want 0", alarm_hit);
            end
        end
        alarm_en = 1'b1;
        set_time(7, 29);
        inc_min = 1'b1; cycle(); inc_min = 1'b0;
        checks++;
        if (alarm_hit !== 1'b0 || obs_digits() !== 24'h073000) begin
            errors++;
            $display("FAIL alarm_via_set got hit=%b time=%h want hit=0 time=073000", alarm_hit, obs_digits());
        end
        alarm_en = 1'b0;
    endtask

    task automatic test_run_hold();
        logic [23:0] snap;
        int p, n;
        run = 1'b1;
        cycle(); cycle();
        p = m_presc;
        snap = obs_digits();
        run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (obs_digits() !== snap || sec_pulse !== 1'b0) begin
                errors++;
                $display("FAIL run_hold got %h sp=%b want %h sp=0", obs_digits(), sec_pulse, snap);
            end
        end
        run = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (sec_pulse !== 1'b1 && n < 10);
        checks++;
        if (n !== CLK_HZ - p || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL resume_tick got %0d cycles want %0d", n, CLK_HZ - p);
        end
        n = 0;
        while (m_presc != CLK_HZ - 1 && n < 10) begin cycle(); n++; end
        inc_min = 1'b1; cycle(); inc_min = 1'b0;
        checks++;
        if (sec_pulse !== 1'b0 || {sec_hi, sec_lo} !== 8'h00 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL set_beats_tick got sp=%b sec=%h want sp=0 sec=00", sec_pulse, {sec_hi, sec_lo});
        end
        cycle();
        checks++;
        if (sec_pulse !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL set_beats_tick_after got %h want %h", obs_vec(), exp_vec());
        end
    endtask

`ifdef TWELVE_HOUR_EN
    task automatic test_twelve_hour();
        int n;
        set_time(11, 59);
        run_to(11 * 3600 + 59 * 60 + 59);
        n = 0;
        do begin cycle(); n++; end while (sec_pulse !== 1'b1 && n < 10);
        checks++;
        if (obs_digits() !== 24'h120000 || pm !== 1'b1) begin
            errors++;
            $display("FAIL noon got %h pm=%b want 120000 pm=1", obs_digits(), pm);
        end
        set_time(12, 59);
        run_to(12 * 3600 + 59 * 60 + 59);
        n = 0;
        do begin cycle(); n++; end while (sec_pulse !== 1'b1 && n < 10);
        checks++;
        if (obs_digits() !== 24'h010000 || pm !== 1'b1) begin
            errors++;
            $display("FAIL one_pm got %h pm=%b want 010000 pm=1", obs_digits(), pm);
        end
    endtask
`endif

    task automatic test_random();
        int h, m, tgt;
        for (int it = 0; it < 5; it++) begin
            h = $urandom_range(0, 23);
            m = ($urandom_range(0, 1) == 0) ? 59 : $urandom_range(0, 59);
            if (it == 0) h = 23;
            set_time(h, m);
            tgt = (h * 3600 + m * 60 + 60) % DAY;
`ifdef TWELVE_HOUR_EN
            alarm_hh = bcd(((tgt / 3600) % 12 == 0) ? 12 : (tgt / 3600) % 12);
            alarm_pm = ((tgt / 3600) >= 12);
`else
            alarm_hh = bcd(tgt / 3600);
`endif
            alarm_mm = bcd((tgt / 60) % 60);
            if (it == 3) alarm_mm = 8'h3A;
            alarm_en = (it != 2);
            for (int c = 0; c < 400; c++) begin
                run     = ($urandom_range(0, 9) != 0);
                inc_min = ($urandom_range(0, 149) == 0);
                inc_hr  = ($urandom_range(0, 149) == 0);
                reset   = ($urandom_range(0, 999) == 0);
                cycle();
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL random it=%0d c=%0d got %h want %h", it, c, obs_vec(), exp_vec());
                end
            end
            inc_min = 1'b0; inc_hr = 1'b0; reset = 1'b0;
        end
        alarm_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_day_wrap();
        test_set_pulses();
        test_alarm();
        test_run_hold();
`ifdef TWELVE_HOUR_EN
        test_twelve_hour();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
